hazard_tracker: RTL and testbench

- Consumer side of the per-instruction A/T decode. Takes the D-stage register addresses, Tuse flags and result-source code, and keeps its own shadow copy of them for the E, M and W stages.
- From that shadow pipeline it drives the D-stage stall and every forwarding-mux select in the 5-stage MIPS core.
- Sits beside the datapath pipeline registers. It owns its A/resOp copies, so the datapath registers do not carry hazard fields.

---
 rtl/hazard_tracker_if.sv | 34 +++
 rtl/hazard_tracker.sv | 112 +++++++++++
 tb/tb_hazard_tracker.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/hazard_tracker_if.sv
// D-stage hazard fields from the decoder plus the stall/forward controls returned to the datapath.
// The decoder side drives the D fields and the tracker drives the controls.
interface hazard_tracker_if #(
    parameter int CNT_W = 32
);
    logic [4:0]       A1D;
    logic [4:0]       A2D;
    logic [4:0]       A3D;
    logic [1:0]       resOpD;
    logic             Tuse_rs0;
    logic             Tuse_rs1;
    logic             Tuse_rt0;
    logic             Tuse_rt1;
    logic             Tuse_rt2;
    logic             stall;
    logic [1:0]       fwd_rs_d;
    logic [1:0]       fwd_rt_d;
    logic [1:0]       fwd_rs_e;
    logic [1:0]       fwd_rt_e;
    logic             fwd_rt_m;
    logic [CNT_W-1:0] stall_count;

    modport master (
        output A1D, A2D, A3D, resOpD,
        output Tuse_rs0, Tuse_rs1, Tuse_rt0, Tuse_rt1, Tuse_rt2,
        input  stall, fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e, fwd_rt_m, stall_count
    );

    modport slave (
        input  A1D, A2D, A3D, resOpD,
        input  Tuse_rs0, Tuse_rs1, Tuse_rt0, Tuse_rt1, Tuse_rt2,
        output stall, fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e, fwd_rt_m, stall_count
    );
endinterface

// File: rtl/hazard_tracker.sv
// Shadow E/M/W copies of the register addresses and result source, driving the D-stage stall,
// every forwarding select of the 5-stage core, and a saturating count of stalled cycles.
module hazard_tracker #(
    parameter int CNT_W = 32
) (
    input logic             clk,
    input logic             reset,
    hazard_tracker_if.slave hz
);
    localparam logic [1:0] OP_NW  = 2'd0;
    localparam logic [1:0] OP_ALU = 2'd1;
    localparam logic [1:0] OP_DM  = 2'd2;
    localparam logic [1:0] OP_PC  = 2'd3;

    logic [4:0]       A1E, A2E, A3E, A2M, A3M, A3W;
    logic [1:0]       resOpE, resOpM, resOpW;
    logic [CNT_W-1:0] stall_cnt;

    logic [1:0] tnew_e, tnew_m;
    logic [1:0] tuse_rs, tuse_rt;
    logic       need_rs, need_rt;
    logic       stall_rs, stall_rt, stall_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            A1E       <= '0;
            A2E       <= '0;
            A3E       <= '0;
            resOpE    <= OP_NW;
            A2M       <= '0;
            A3M       <= '0;
            resOpM    <= OP_NW;
            A3W       <= '0;
            resOpW    <= OP_NW;
            stall_cnt <= '0;
        end else begin
            if (stall_d) begin
                A1E    <= '0;
                A2E    <= '0;
                A3E    <= '0;
                resOpE <= OP_NW;
            end else begin
                A1E    <= hz.A1D;
                A2E    <= hz.A2D;
                A3E    <= hz.A3D;
                resOpE <= hz.resOpD;
            end
            A2M    <= A2E;
            A3M    <= A3E;
            resOpM <= resOpE;
            A3W    <= A3M;
            resOpW <= resOpM;
            if (stall_d && (stall_cnt != {CNT_W{1'b1}}))
                stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

    always_comb begin
        tnew_e = 2'd0;
        case (resOpE)
            OP_ALU:  tnew_e = 2'd1;
            OP_DM:   tnew_e = 2'd2;
            default: tnew_e = 2'd0;
        endcase
        tnew_m = (resOpM == OP_DM) ? 2'd1 : 2'd0;
    end

    // The earliest stage that needs an operand sets its Tuse; an operand nobody reads never stalls.
    always_comb begin
        need_rs = hz.Tuse_rs0 | hz.Tuse_rs1;
        tuse_rs = hz.Tuse_rs0 ? 2'd0 : 2'd1;
        need_rt = hz.Tuse_rt0 | hz.Tuse_rt1 | hz.Tuse_rt2;
        tuse_rt = hz.Tuse_rt0 ? 2'd0 : (hz.Tuse_rt1 ? 2'd1 : 2'd2);

        stall_rs = need_rs && (hz.A1D != 5'd0) &&
                   (((hz.A1D == A3E) && (tuse_rs < tnew_e)) ||
                    ((hz.A1D == A3M) && (tuse_rs < tnew_m)));
        stall_rt = need_rt && (hz.A2D != 5'd0) &&
                   (((hz.A2D == A3E) && (tuse_rt < tnew_e)) ||
                    ((hz.A2D == A3M) && (tuse_rt < tnew_m)));
        stall_d  = stall_rs | stall_rt;
    end

    // A younger writer whose value is not ready yet masks older matches; stall covers that case.
    function automatic logic [1:0] sel_from_m(input logic [4:0] a);
        if ((a == A3M) && (resOpM != OP_NW))
            return (resOpM == OP_DM) ? 2'd0 : 2'd2;
        else if ((a == A3W) && (resOpW != OP_NW))
            return 2'd3;
        else
            return 2'd0;
    endfunction

    function automatic logic [1:0] sel_from_e(input logic [4:0] a);
        if (a == 5'd0)
            return 2'd0;
        else if ((a == A3E) && (resOpE != OP_NW))
            return (resOpE == OP_PC) ? 2'd1 : 2'd0;
        else
            return sel_from_m(a);
    endfunction

    always_comb begin
        hz.stall       = stall_d;
        hz.fwd_rs_d    = sel_from_e(hz.A1D);
        hz.fwd_rt_d    = sel_from_e(hz.A2D);
        hz.fwd_rs_e    = (A1E == 5'd0) ? 2'd0 : sel_from_m(A1E);
        hz.fwd_rt_e    = (A2E == 5'd0) ? 2'd0 : sel_from_m(A2E);
        hz.fwd_rt_m    = (A2M != 5'd0) && (A2M == A3W) && (resOpW != OP_NW);
        hz.stall_count = stall_cnt;
    end
endmodule

// File: tb/tb_hazard_tracker.sv
// Directed bench for hazard_tracker: a stage-record model checked every cycle plus literal
// expectations for the classic load-use, branch, jal/jr, store-data and $0 sequences.
module tb_hazard_tracker;
    localparam int CNT_W = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;
    localparam logic [1:0] NW = 2'd0, ALU = 2'd1, DM = 2'd2, PC = 2'd3;
    localparam logic [4:0] RS0 = 5'b00001, RS1 = 5'b00010, RT1 = 5'b01000, RT2 = 5'b10000;

    logic clk;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    hazard_tracker_if #(.CNT_W(CNT_W)) hz ();
    hazard_tracker #(.CNT_W(CNT_W)) dut (.clk(clk), .reset(rst), .hz(hz));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: one record per in-flight instruction, index 0=E, 1=M, 2=W.
    typedef struct packed {
        logic [4:0] a1;
        logic [4:0] a2;
        logic [4:0] a3;
        logic [1:0] op;
    } rec_t;

    rec_t st [3];
    int   mcnt;

    // Pipeline depth (from E) at which the result becomes available; -1 for non-writers.
    function automatic int prod(input logic [1:0] op);
        case (op)
            ALU:     return 1;
            DM:      return 2;
            PC:      return 0;
            default: return -1;
        endcase
    endfunction

    function automatic int tnew(input rec_t r, input int depth);
        int t = prod(r.op) - depth;
        return (t < 0) ? 0 : t;
    endfunction

    function automatic bit writes(input rec_t r, input logic [4:0] a);
        return (a != 5'd0) && (r.a3 == a) && (r.op != NW);
    endfunction

    function automatic int fwd(input logic [4:0] a, input int first);
        for (int s = first; s < 3; s++)
            if (writes(st[s], a)) return (tnew(st[s], s) == 0) ? s + 1 : 0;
        return 0;
    endfunction

    function automatic bit stall_of(input logic [4:0] a, input int tuse);
        for (int s = 0; s < 2; s++)
            if (writes(st[s], a) && (tuse < tnew(st[s], s))) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit model_stall();
        int trs = hz.Tuse_rs0 ? 0 : (hz.Tuse_rs1 ? 1 : 9);
        int trt = hz.Tuse_rt0 ? 0 : (hz.Tuse_rt1 ? 1 : (hz.Tuse_rt2 ? 2 : 9));
        return stall_of(hz.A1D, trs) || stall_of(hz.A2D, trt);
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            st[0] <= '0;
            st[1] <= '0;
            st[2] <= '0;
            mcnt  <= 0;
        end else begin
            st[0] <= model_stall() ? rec_t'(0) : {hz.A1D, hz.A2D, hz.A3D, hz.resOpD};
            st[1] <= st[0];
            st[2] <= st[1];
            if (model_stall() && (mcnt < CNT_MAX)) mcnt <= mcnt + 1;
        end
    end

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        check("m_stall",    int'(hz.stall),       int'(model_stall()));
        check("m_fwd_rs_d", int'(hz.fwd_rs_d),    fwd(hz.A1D, 0));
        check("m_fwd_rt_d", int'(hz.fwd_rt_d),    fwd(hz.A2D, 0));
        check("m_fwd_rs_e", int'(hz.fwd_rs_e),    fwd(st[0].a1, 1));
        check("m_fwd_rt_e", int'(hz.fwd_rt_e),    fwd(st[0].a2, 1));
        check("m_fwd_rt_m", int'(hz.fwd_rt_m),    (fwd(st[1].a2, 2) == 3) ? 1 : 0);
        check("m_count",    int'(hz.stall_count), mcnt);
    end

    task automatic drive(input logic [4:0] a1, input logic [4:0] a2, input logic [4:0] a3,
                         input logic [1:0] op, input logic [4:0] tuse);
        hz.A1D      = a1;
        hz.A2D      = a2;
        hz.A3D      = a3;
        hz.resOpD   = op;
        hz.Tuse_rs0 = tuse[0];
        hz.Tuse_rs1 = tuse[1];
        hz.Tuse_rt0 = tuse[2];
        hz.Tuse_rt1 = tuse[3];
        hz.Tuse_rt2 = tuse[4];
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic flush(input int n);
        drive(0, 0, 0, NW, 0);
        repeat (n) step();
    endtask

    initial begin
        rst = 1'b1;
        drive(8, 9, 8, DM, RS0 | RS1 | RT1);
        step();
        step();
        @(negedge clk);
        check("rst_stall", int'(hz.stall), 0);
        check("rst_fwd_rs_d", int'(hz.fwd_rs_d), 0);
        check("rst_fwd_rt_d", int'(hz.fwd_rt_d), 0);
        check("rst_count", int'(hz.stall_count), 0);
        step();
        rst = 1'b0;
        flush(2);

        // lw $8 ; addu using $8 in E
        drive(0, 0, 8, DM, 0);
        step();
        drive(8, 0, 10, ALU, RS1);
        @(negedge clk);
        check("lw_use_stall", int'(hz.stall), 1);
        step();
        @(negedge clk);
        check("lw_use_release", int'(hz.stall), 0);
        check("lw_bubble_fwd_rs_e", int'(hz.fwd_rs_e), 0);
        step();
        drive(0, 0, 0, NW, 0);
        @(negedge clk);
        check("lw_use_fwd_rs_e", int'(hz.fwd_rs_e), 3);
        check("lw_use_count", int'(hz.stall_count), 1);
        flush(3);

        // ori $8 ; beq on $8 in D
        drive(0, 0, 8, ALU, 0);
        step();
        drive(8, 0, 0, NW, RS0);
        @(negedge clk);
        check("br_stall", int'(hz.stall), 1);
        step();
        @(negedge clk);
        check("br_release", int'(hz.stall), 0);
        check("br_fwd_rs_d", int'(hz.fwd_rs_d), 2);
        check("br_count", int'(hz.stall_count), 2);
        step();
        flush(3);

        // jal ; jr $31
        drive(0, 0, 31, PC, 0);
        step();
        drive(31, 0, 0, NW, RS0);
        @(negedge clk);
        check("jr_stall", int'(hz.stall), 0);
        check("jr_fwd_rs_d", int'(hz.fwd_rs_d), 1);
        step();
        flush(3);

        // lw $9 ; sw $9 store data forwarded in M
        drive(0, 0, 9, DM, 0);
        step();
        drive(0, 9, 0, NW, RT2);
        @(negedge clk);
        check("sw_stall_d", int'(hz.stall), 0);
        step();
        drive(0, 0, 0, NW, 0);
        @(negedge clk);
        check("sw_fwd_rt_e", int'(hz.fwd_rt_e), 0);
        step();
        @(negedge clk);
        check("sw_fwd_rt_m", int'(hz.fwd_rt_m), 1);
        flush(3);

        // writer of $0 never matches
        drive(0, 0, 0, ALU, 0);
        step();
        drive(0, 0, 0, NW, RS0);
        @(negedge clk);
        check("r0_stall", int'(hz.stall), 0);
        check("r0_fwd_rs_d", int'(hz.fwd_rs_d), 0);
        flush(3);

        // ori $7 in W seen by both D operands
        drive(0, 0, 7, ALU, 0);
        step();
        flush(2);
        drive(7, 7, 0, NW, RS1 | RT1);
        @(negedge clk);
        check("w_fwd_rs_d", int'(hz.fwd_rs_d), 3);
        check("w_fwd_rt_d", int'(hz.fwd_rt_d), 3);
        flush(3);

        // two ALU writers of $6: the younger one in E masks the forwardable one in M
        drive(0, 0, 6, ALU, 0);
        step();
        step();
        drive(6, 0, 0, NW, RS1);
        @(negedge clk);
        check("mask_stall", int'(hz.stall), 0);
        check("mask_fwd_rs_d", int'(hz.fwd_rs_d), 0);
        flush(3);

        // reset arriving while stalled
        drive(0, 0, 5, DM, 0);
        step();
        drive(5, 0, 0, NW, RS0);
        @(negedge clk);
        check("pre_rst_stall", int'(hz.stall), 1);
        #1 rst = 1'b1;
        #1;
        check("mid_rst_stall", int'(hz.stall), 0);
        check("mid_rst_count", int'(hz.stall_count), 0);
        step();
        rst = 1'b0;

        // self-dependent loads keep stalling until the counter saturates
        drive(5, 0, 5, DM, RS0);
        repeat (40) step();
        @(negedge clk);
        check("sat_count", int'(hz.stall_count), CNT_MAX);
        flush(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
